// File: rtl/mem_unit_pkg.sv
// Shared definitions for the load/store stage: decoded instruction struct,
// access-size and FSM state enums, and store-lane helper functions.
package mem_unit_pkg;

  typedef struct packed {
    logic lui;
    logic addi;
    logic add;
    logic sub;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (size)
      HALF:    r = off[0];
      WORD:    r = |off;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input mem_size_t size, input logic [1:0] off);
    logic [3:0] r;
    r = 4'b0000;
    case (size)
      BYTE:    r = 4'b0001 << off;
      HALF:    r = 4'b0011 << off;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Data is replicated across lanes so the strobe alone selects the bytes.
  function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] data);
    logic [31:0] r;
    r = data;
    case (size)
      BYTE:    r = {4{data[7:0]}};
      HALF:    r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Data-memory request/acknowledge bus: the master holds mem_req and all
// request fields stable until the slave pulses mem_ack (read data valid with ack).
interface mem_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_unit_load_align.sv
// Combinational little-endian load extraction with sign/zero extension;
// kept standalone so a cache read path can share it.
module load_align
  import mem_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      BYTE:    o_data = i_unsigned ? {24'd0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_data = i_unsigned ? {16'd0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Multi-cycle load/store stage: one request/acknowledge transaction per
// memory instruction, one-cycle done pulse with extended load data or fault.
module mem_unit
  import mem_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  instructions i_instr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_v,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_load_v,
  output mem_state_t  o_state,
  mem_unit_if.master  bus
);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;

  logic        r_is_load;
  mem_size_t   r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic        r_fault;
  logic [31:0] r_load_v;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  mem_size_t   w_size;
  logic        w_unsigned;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_ack;
  logic [31:0] w_load_aligned;
  logic        w_unused_instr;

  assign w_is_load  = i_instr.lb | i_instr.lh | i_instr.lw | i_instr.lbu | i_instr.lhu;
  assign w_is_store = i_instr.sb | i_instr.sh | i_instr.sw;
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_unsigned = i_instr.lbu | i_instr.lhu;
  assign w_unused_instr = ^{i_instr.lui, i_instr.addi, i_instr.add, i_instr.sub};

  always_comb begin
    w_size = WORD;
    if (i_instr.lb | i_instr.lbu | i_instr.sb)
      w_size = BYTE;
    else if (i_instr.lh | i_instr.lhu | i_instr.sh)
      w_size = HALF;
  end

  assign w_misaligned = is_misaligned(w_size, i_addr[1:0]);
  assign w_accept     = (r_state == IDLE) && i_start && w_is_mem;
  // Ack is only meaningful while a request is outstanding.
  assign w_ack        = (r_state == REQ) && bus.mem_ack;

  load_align u_load_align (
    .i_rdata    (bus.mem_rdata),
    .i_offset   (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_aligned)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_misaligned ? RESP : REQ;
      REQ:     if (bus.mem_ack) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_load  <= 1'b0;
      r_size     <= BYTE;
      r_unsigned <= 1'b0;
      r_off      <= 2'd0;
      r_fault    <= 1'b0;
      r_load_v   <= 32'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
    end else if (w_accept) begin
      r_is_load  <= w_is_load;
      r_size     <= w_size;
      r_unsigned <= w_unsigned;
      r_off      <= i_addr[1:0];
      r_fault    <= w_misaligned;
      r_load_v   <= 32'd0;
      if (!w_misaligned) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= {i_addr[31:2], 2'b00};
        r_wdata <= w_is_store ? store_lanes(w_size, i_store_v) : 32'd0;
        r_wstrb <= w_is_store ? store_strb(w_size, i_addr[1:0]) : 4'd0;
      end
    end else if (w_ack) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_load_v <= r_is_load ? w_load_aligned : 32'd0;
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_done   = (r_state == RESP);
  assign o_fault  = r_fault;
  assign o_load_v = r_load_v;
  assign o_state  = r_state;

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;

endmodule

// File: doc/mem_unit.md
# mem_unit

Multi-cycle load/store stage directly downstream of the ALU. It takes the effective address computed for `lb/lh/lw/lbu/lhu/sb/sh/sw` plus the store operand and performs one request/acknowledge transaction on the data-memory bus. Store data is placed on the correct byte lanes with matching write strobes. Load data is extracted and sign- or zero-extended, then handed to write-back with a one-cycle `done` pulse.

## Interface

No parameters (32-bit data/address fixed).

- `clk` — in, 1: sole clock, rising edge.
- `rst` — in, 1: asynchronous, active-high reset.
- `start` — in, 1: launch request; sampled only in IDLE.
- `instr` — in, `instructions`: decoded instruction struct; only `lb, lh, lw, lbu, lhu, sb, sh, sw` are used.
- `addr` — in, 32: byte effective address (ALU result).
- `store_v` — in, 32: rs2 value for stores.
- `busy` — out, 1: high whenever state ≠ IDLE.
- `done` — out, 1: one-cycle completion pulse.
- `fault` — out, 1: misaligned access; valid with `done`.
- `load_v` — out, 32: extended load result; valid with `done`, 0 for stores and faults.
- `mem_req` — out, 1: bus request, held until ack.
- `mem_we` — out, 1: 1 = write.
- `mem_addr` — out, 32: word-aligned address, `{addr[31:2], 2'b00}`.
- `mem_wdata` — out, 32: lane-shifted store data.
- `mem_wstrb` — out, 4: byte enables; 0 for reads.
- `mem_ack` — in, 1: transaction complete; for reads, `mem_rdata` is valid this cycle.
- `mem_rdata` — in, 32: read word.

## Operation

**States:** IDLE, REQ, RESP.

- **IDLE:** On `start` with a memory op, latch op class, `addr[1:0]`, the aligned address and lane data, then check alignment.
  - Misaligned → RESP with `fault = 1`, no bus activity.
  - Aligned → REQ.
  - `start` with no memory op set → ignored.
- **REQ:** Drive `mem_req = 1` and hold all `mem_*` outputs stable until `mem_ack`. On `mem_ack`, register the aligned and extended read data → RESP.
- **RESP:** `done = 1` for exactly one cycle → IDLE.

**Alignment rules:**
- `lh/lhu/sh` require `addr[0] = 0`.
- `lw/sw` require `addr[1:0] = 0`.
- Byte ops are always aligned.

**Store lanes:**
- `sb`: data = `{4{store_v[7:0]}}`, strobe = `4'b0001 << addr[1:0]`.
- `sh`: data = `{2{store_v[15:0]}}`, strobe = `4'b0011 << addr[1:0]`.
- `sw`: data = `store_v`, strobe = `4'b1111`.

**Load extraction** (little-endian):
- Byte = `mem_rdata >> (8*addr[1:0])`, bits [7:0].
- Half = `mem_rdata >> (8*addr[1:0])`, bits [15:0].
- `lb/lh` sign-extend; `lbu/lhu` zero-extend; `lw` passes through.

**Reset:**
- All outputs reset to 0 and state to IDLE.
- `rst` mid-transaction drops `mem_req` immediately. A late `mem_ack` arriving in IDLE is ignored.

## Timing

- `start` at cycle N (aligned):
  - `mem_req` is high from N+1.
  - If `mem_ack` arrives at cycle M ≥ N+1, `done` pulses at M+1.
  - Minimum latency is 2 cycles (ack in the first REQ cycle).
- Misaligned `start` at N → `done` + `fault` at N+1, `mem_req` never asserted.
- `start` while `busy` is ignored. The next `start` may be accepted in the cycle after `done`.
- `mem_ack` outside REQ has no effect.
- `mem_*` outputs are registered. They change only on entry to REQ and return to 0 on leaving REQ.
- There is no timeout: the unit waits in REQ indefinitely.

## Structure

- The `instructions` struct stays in the shared definitions file. Add to it:
  - a `mem_size_t` enum (BYTE, HALF, WORD);
  - the state enum `mem_state_t`.
- Sub-module `load_align`: combinational; inputs `rdata`, offset, size, unsigned flag; output the extended word. It is reused by any future cache path.

## Test plan

- **`lw` hit:** `lw`, addr `0x100`, ack in first REQ cycle with rdata `0xDEADBEEF` → `done` 2 cycles after `start`, `load_v = 0xDEADBEEF`, `mem_addr = 0x100`.
- **Byte loads, delayed ack:** `lb` at `0x103`, rdata `0x80FF_FF12`, ack after 3 wait cycles → `load_v = 0xFFFFFF80`. Repeat with `lbu` → `load_v = 0x00000080`.
- **`sh` lanes:** `sh` addr `0x22`, `store_v = 0x1234ABCD` → `mem_we = 1`, `mem_wstrb = 4'b1100`, `mem_wdata = 0xABCDABCD`, `mem_addr = 0x20`, `load_v = 0`.
- **Misaligned:** `lw` at `0x101` → `done` and `fault` at N+1, `mem_req` never high. Same for `sh` at `0x03`.
- **`start` while busy:** second `start` during REQ → ignored, exactly one bus transaction and one `done`.
- **Reset mid-transaction:** `rst` during REQ → `mem_req` low immediately. Ack after release → no `done`. The next `lhu` at `0x02` with rdata `0xBEEF0000` → `load_v = 0x0000BEEF`.
